// File: rtl/shift_sequencer.sv
// Shift-register sequencer: one LOAD, bounded SHIFT steps, then a done pulse.
// Optional abort input enabled by defining SHIFT_ABORT_EN.
module shift_sequencer #(
    parameter int unsigned STEP_MAX = 1,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] shift_op,
    input  logic [4:0] shamt,
    input  logic       src_sel,
`ifdef SHIFT_ABORT_EN
    input  logic       abort,
`endif
    output logic [2:0] SHIFTER_control,
    output logic [4:0] shift_n,
    output logic       M_SHIFTER,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [2:0] C_HOLD = 3'b000;
    localparam logic [2:0] C_LOAD = 3'b001;
    localparam logic [CNT_W-1:0] STEP = CNT_W'(STEP_MAX);

    state_t           state_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] step_d;
    logic [CNT_W-1:0] rem_d;
    logic [2:0]       ctrl_q;
    logic [4:0]       n_q;
    logic             m_q;
    logic             busy_q;
    logic             done_q;
    logic             abort_w;

`ifdef SHIFT_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Each step is clamped to what is left, so the counter cannot underflow.
    always_comb begin
        step_d = (rem_q > STEP) ? STEP : rem_q;
        rem_d  = rem_q - step_d;
    end

    function automatic logic [2:0] op_code(input logic [1:0] op);
        logic [2:0] c;
        c = C_HOLD;
        unique case (op)
            2'b00: c = 3'b010;
            2'b01: c = 3'b011;
            2'b10: c = 3'b100;
            2'b11: c = 3'b101;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            rem_q   <= '0;
            ctrl_q  <= C_HOLD;
            n_q     <= 5'd0;
            m_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort_w &&
                     (state_q == S_LOAD || state_q == S_SHIFT)) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            ctrl_q  <= C_HOLD;
            n_q     <= 5'd0;
            m_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    ctrl_q <= C_HOLD;
                    n_q    <= 5'd0;
                    m_q    <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_LOAD;
                        op_q    <= shift_op;
                        rem_q   <= CNT_W'(shamt);
                        m_q     <= src_sel;
                        ctrl_q  <= C_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD, S_SHIFT: begin
                    if (rem_q != '0) begin
                        state_q <= S_SHIFT;
                        ctrl_q  <= op_code(op_q);
                        n_q     <= 5'(step_d);
                        rem_q   <= rem_d;
                    end else begin
                        state_q <= S_DONE;
                        ctrl_q  <= C_HOLD;
                        n_q     <= 5'd0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ctrl_q  <= C_HOLD;
                    n_q     <= 5'd0;
                    m_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign SHIFTER_control = ctrl_q;
    assign shift_n         = n_q;
    assign M_SHIFTER       = m_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with STEP_MAX=1 and STEP_MAX=4 instances.
// Abort scenario runs only when SHIFT_ABORT_EN is defined.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start4;
    logic [1:0] shift_op;
    logic [4:0] shamt;
    logic       src_sel;
    logic       abort;

    logic [2:0] c1, c4;
    logic [4:0] n1, n4;
    logic       m1, m4, b1, b4, d1, d4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.STEP_MAX(1), .CNT_W(5)) u1 (
        .clk(clk), .reset(reset), .start(start1),
        .shift_op(shift_op), .shamt(shamt), .src_sel(src_sel),
`ifdef SHIFT_ABORT_EN
        .abort(abort),
`endif
        .SHIFTER_control(c1), .shift_n(n1), .M_SHIFTER(m1),
        .busy(b1), .done(d1)
    );

    shift_sequencer #(.STEP_MAX(4), .CNT_W(5)) u4 (
        .clk(clk), .reset(reset), .start(start4),
        .shift_op(shift_op), .shamt(shamt), .src_sel(src_sel),
`ifdef SHIFT_ABORT_EN
        .abort(abort),
`endif
        .SHIFTER_control(c4), .shift_n(n4), .M_SHIFTER(m4),
        .busy(b4), .done(d4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
        shift_op = 2'b00; shamt = 5'd0; src_sel = 1'b0; abort = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({c1, n1, m1, b1, d1} !== 11'd0) begin
            errors++;
            $display("FAIL reset_u1: got %b expected 0", {c1, n1, m1, b1, d1});
        end
        checks++;
        if ({c4, n4, m4, b4, d4} !== 11'd0) begin
            errors++;
            $display("FAIL reset_u4: got %b expected 0", {c4, n4, m4, b4, d4});
        end
        reset = 1'b1; start1 = 1'b1; shamt = 5'd2;
        tick();
        reset = 1'b0; start1 = 1'b0;
        tick();
        checks++;
        if (b1 !== 1'b0 || c1 !== 3'b000) begin
            errors++;
            $display("FAIL start_with_reset: busy %b ctrl %b expected 0 000", b1, c1);
        end
    endtask

    task automatic test_sll_step1();
        int ec[5] = '{1, 2, 2, 2, 0};
        int en[5] = '{0, 1, 1, 1, 0};
        int dones = 0;
        shift_op = 2'b00; shamt = 5'd3; src_sel = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0; shamt = 5'd7; shift_op = 2'b11;
        for (int i = 0; i < 5; i++) begin
            if (d1) dones++;
            checks++;
            if (c1 !== 3'(ec[i]) || n1 !== 5'(en[i]) || b1 !== 1'b1 ||
                d1 !== (i == 4)) begin
                errors++;
                $display("FAIL sll_cyc%0d: ctrl %0d n %0d busy %b done %b expected %0d %0d 1 %b",
                         i + 1, c1, n1, b1, d1, ec[i], en[i], i == 4);
            end
            tick();
        end
        checks++;
        if (b1 !== 1'b0 || d1 !== 1'b0 || c1 !== 3'b000 || dones != 1) begin
            errors++;
            $display("FAIL sll_end: busy %b done %b ctrl %0d pulses %0d expected 0 0 0 1",
                     b1, d1, c1, dones);
        end
    endtask

    task automatic test_sra_step4();
        int ec[5] = '{1, 4, 4, 4, 0};
        int en[5] = '{0, 4, 4, 2, 0};
        shift_op = 2'b10; shamt = 5'd10; src_sel = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (c4 !== 3'(ec[i]) || n4 !== 5'(en[i]) || d4 !== (i == 4)) begin
                errors++;
                $display("FAIL sra_cyc%0d: ctrl %0d n %0d done %b expected %0d %0d %b",
                         i + 1, c4, n4, d4, ec[i], en[i], i == 4);
            end
            tick();
        end
        checks++;
        if (b4 !== 1'b0) begin
            errors++;
            $display("FAIL sra_end: busy %b expected 0", b4);
        end
    endtask

    task automatic test_ror_zero();
        shift_op = 2'b11; shamt = 5'd0; src_sel = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0; src_sel = 1'b0;
        checks++;
        if (c1 !== 3'b001 || m1 !== 1'b1 || b1 !== 1'b1 || d1 !== 1'b0) begin
            errors++;
            $display("FAIL ror0_load: ctrl %0d m %b busy %b done %b expected 1 1 1 0",
                     c1, m1, b1, d1);
        end
        tick();
        checks++;
        if (c1 !== 3'b000 || n1 !== 5'd0 || m1 !== 1'b1 || d1 !== 1'b1) begin
            errors++;
            $display("FAIL ror0_done: ctrl %0d n %0d m %b done %b expected 0 0 1 1",
                     c1, n1, m1, d1);
        end
        tick();
        checks++;
        if (b1 !== 1'b0 || d1 !== 1'b0) begin
            errors++;
            $display("FAIL ror0_idle: busy %b done %b expected 0 0", b1, d1);
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        shift_op = 2'b01; shamt = 5'd5; src_sel = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (d1) dones++;
            if (c >= 2 && c <= 6) begin
                checks++;
                if (c1 !== 3'b011 || n1 !== 5'd1) begin
                    errors++;
                    $display("FAIL srl_cyc%0d: ctrl %0d n %0d expected 3 1", c, c1, n1);
                end
            end
            if (c == 7) begin
                checks++;
                if (d1 !== 1'b1) begin
                    errors++;
                    $display("FAIL srl_done: done %b expected 1", d1);
                end
            end
            if (c == 8) begin
                checks++;
                if (b1 !== 1'b0) begin
                    errors++;
                    $display("FAIL srl_idle: busy %b expected 0", b1);
                end
            end
            start1 = (c == 3 || c == 7);
            shift_op = (c == 3) ? 2'b00 : 2'b01;
            shamt = (c == 3) ? 5'd9 : 5'd5;
            tick();
        end
        start1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (d1) dones++;
            tick();
        end
        checks++;
        if (dones != 1 || b1 !== 1'b0) begin
            errors++;
            $display("FAIL srl_pulses: pulses %0d busy %b expected 1 0", dones, b1);
        end
        shift_op = 2'b00; shamt = 5'd1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (c1 !== 3'b001 || b1 !== 1'b1) begin
            errors++;
            $display("FAIL restart_load: ctrl %0d busy %b expected 1 1", c1, b1);
        end
        tick(); tick();
        checks++;
        if (d1 !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: done %b expected 1", d1);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        shift_op = 2'b00; shamt = 5'd31; src_sel = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (c1 !== 3'b010 || b1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_shift: ctrl %0d busy %b expected 2 1", c1, b1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({c1, n1, m1, b1, d1} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset: got %b expected 0", {c1, n1, m1, b1, d1});
        end
        shamt = 5'd1; src_sel = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        checks++;
        if (c1 !== 3'b010 || n1 !== 5'd1) begin
            errors++;
            $display("FAIL post_reset_shift: ctrl %0d n %0d expected 2 1", c1, n1);
        end
        tick();
        checks++;
        if (d1 !== 1'b1 || c1 !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_done: done %b ctrl %0d expected 1 0", d1, c1);
        end
        tick();
    endtask

`ifdef SHIFT_ABORT_EN
    task automatic test_abort();
        int dones = 0;
        shift_op = 2'b01; shamt = 5'd6; src_sel = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(); tick();
        checks++;
        if (c1 !== 3'b011 || b1 !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: ctrl %0d busy %b expected 3 1", c1, b1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (c1 !== 3'b000 || b1 !== 1'b0 || d1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: ctrl %0d busy %b done %b expected 0 0 0",
                     c1, b1, d1);
        end
        for (int i = 0; i < 8; i++) begin
            if (d1 || b1) dones++;
            tick();
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_quiet: active cycles %0d expected 0", dones);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sll_step1();
        test_sra_step4();
        test_ror_zero();
        test_ignore_start();
        test_reset_mid();
`ifdef SHIFT_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multicycle controller that sequences the shift register (RegDesloc) for sll/srl/sra/sllv/srlv/srav/lui-style operations. It accepts one request from the main control unit, issues a LOAD, then repeated bounded shift steps until the full amount is applied, then pulses done. This moves shift-cycle counting out of the ALU control decode and the main FSM.

Parameters:
STEP_MAX, 1, maximum shift distance issued per cycle (1..31); amounts larger than this take several SHIFT cycles.
CNT_W, 5, width of the shift-amount counter; covers 0..31.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  request pulse; sampled only in IDLE
shift_op  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROR
shamt  input  5  shift amount (instr[10:6] or rs[4:0]), sampled with start
src_sel  input  1  shifter input select: 0=register B, 1=immediate (lui path)
SHIFTER_control  output  3  000 hold, 001 load, 010 left, 011 right logical, 100 right arithmetic, 101 rotate right
shift_n  output  5  distance for the current shift step
M_SHIFTER  output  1  registered src_sel, held for the whole operation
busy  output  1  high from the cycle after an accepted start until DONE ends
done  output  1  one-cycle pulse in DONE; shifter result is valid in that cycle

Behaviour:
- All outputs are registered. Reset, including mid-operation, forces state IDLE next edge: SHIFTER_control=000, shift_n=0, M_SHIFTER=0, busy=0, done=0, counter=0.
- States and transitions:
  - IDLE: outputs 000/0/busy=0. If start=1, latch op, shamt and src_sel and go to LOAD.
  - LOAD: SHIFTER_control=001, shift_n=0, busy=1, M_SHIFTER=latched src_sel. Go to SHIFT if remaining>0, otherwise to DONE.
  - SHIFT: SHIFTER_control=code for op; shift_n=min(remaining, STEP_MAX); remaining -= shift_n. Go to DONE when the new remaining=0, otherwise stay in SHIFT.
  - DONE: SHIFTER_control=000, shift_n=0, done=1, busy=1. Go to IDLE unconditionally.
- Latency from the start edge to the done cycle is 2 + ceil(shamt/STEP_MAX) cycles. Example: shamt=0 gives LOAD then DONE, done in the 2nd cycle after start.
- The op-to-code map is fixed: SLL→010, SRL→011, SRA→100, ROR→101.
- start while busy=1 or in DONE is ignored and not queued. start in the same cycle as reset is ignored.
- shamt, shift_op and src_sel may change after acceptance without effect.
- The counter never underflows; shift_n is never greater than remaining.
- No back-to-back operations: at least one IDLE cycle separates DONE from the next LOAD.

Optional Feature:
Macro SHIFT_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 in LOAD or SHIFT forces IDLE on the next edge with SHIFTER_control=000 and no done pulse. abort in IDLE or DONE has no effect. If reset and abort are both asserted, reset has priority.
- Undefined: no abort port; an operation always runs to DONE.

Test Plan:
1. Reset, then STEP_MAX=1, start with SLL and shamt=3 → control sequence 001, 010×3 (shift_n=1 each), 000 with done=1. busy is high for 5 cycles and done pulses for exactly 1.
2. STEP_MAX=4, SRA with shamt=10 → shift_n sequence 4, 4, 2 with code 100; done on the 5th cycle after start.
3. shamt=0, ROR, src_sel=1 → LOAD (M_SHIFTER=1) then DONE with no 101 cycle; done in the 2nd cycle.
4. Second start pulsed during SHIFT of an SRL shamt=5 → ignored; exactly one done pulse. A new start in the IDLE after it is accepted.
5. reset asserted during SHIFT of an SLL shamt=31 → next cycle all outputs are 0 and state is IDLE; a following start with shamt=1 completes normally.
6. With SHIFT_ABORT_EN, abort in the 2nd SHIFT cycle of SRL shamt=6 → IDLE next cycle, done never pulses, busy drops.
